// File: rtl/pwm_multichannel_gen_if.sv
// Bus-level signals of the multichannel PWM generator: buttons, direct duty load,
// alignment-mode select and the PWM/duty outputs.
interface pwm_multichannel_gen_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0]            inc;
    logic [CHANNELS-1:0]            dec;
    logic                           load_valid;
    logic [3:0]                     load_ch;
    logic [CNT_W-1:0]               load_duty;
    logic                           center;
    logic [CHANNELS-1:0]            pwm_out;
    logic                           period_start;
    logic [CHANNELS-1:0][CNT_W-1:0] duty_out;

    modport master (
        output inc, dec, load_valid, load_ch, load_duty, center,
        input  pwm_out, period_start, duty_out
    );
    modport slave (
        input  inc, dec, load_valid, load_ch, load_duty, center,
        output pwm_out, period_start, duty_out
    );
endinterface

// File: rtl/pwm_multichannel_gen.sv
// Multichannel PWM generator: one shared edge/center-aligned counter, per-channel
// debounced inc/dec buttons, shadow/active duty double buffering and registered outputs.
module pwm_channel #(
    parameter int CNT_W     = 8,
    parameter int PERIOD    = 200,
    parameter int STEP      = 10,
    parameter int INIT_DUTY = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_duty_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             pwm_o,
    output logic [CNT_W-1:0] duty_o
);
    localparam logic [CNT_W-1:0] PER    = CNT_W'(PERIOD);
    localparam logic [CNT_W:0]   PER_X  = (CNT_W+1)'(PERIOD);
    localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(STEP);

    logic [1:0]       inc_s_q, dec_s_q;   // [0] newest sample, [1] previous sample
    logic             inc_p, dec_p;
    logic [CNT_W:0]   up_x, dn_x;
    logic [CNT_W-1:0] shadow_q, shadow_d, active_q, cmp_duty;
    logic             pwm_q;

    assign inc_p = sample_en_i & inc_s_q[0] & ~inc_s_q[1];
    assign dec_p = sample_en_i & dec_s_q[0] & ~dec_s_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_s_q <= '0;
            dec_s_q <= '0;
        end else if (sample_en_i) begin
            inc_s_q <= {inc_s_q[0], inc_i};
            dec_s_q <= {dec_s_q[0], dec_i};
        end
    end

    // One extra bit so saturation is detected instead of wrapping; dn_x MSB is the borrow.
    always_comb begin
        up_x     = {1'b0, shadow_q} + STEP_X;
        dn_x     = {1'b0, shadow_q} - STEP_X;
        shadow_d = shadow_q;
        if (load_i)
            shadow_d = (load_duty_i > PER) ? PER : load_duty_i;
        else if (inc_p && !dec_p)
            shadow_d = (up_x > PER_X) ? PER : up_x[CNT_W-1:0];
        else if (dec_p && !inc_p)
            shadow_d = dn_x[CNT_W] ? '0 : dn_x[CNT_W-1:0];
    end

    // At period start the freshly copied duty must already drive the compare.
    assign cmp_duty = start_i ? shadow_q : active_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= CNT_W'(INIT_DUTY);
            active_q <= CNT_W'(INIT_DUTY);
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            if (start_i)
                active_q <= shadow_q;
            pwm_q <= (cnt_i < cmp_duty);
        end
    end

    assign pwm_o  = pwm_q;
    assign duty_o = shadow_q;
endmodule

module pwm_multichannel_gen #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 8,
    parameter int PERIOD    = 200,
    parameter int STEP      = 10,
    parameter int INIT_DUTY = 100,
    parameter int DEB_DIV   = 25000000
) (
    input  logic                   clk,
    input  logic                   rst,
    pwm_multichannel_gen_if.slave  bus_if
);
    localparam int               DIV_W    = $clog2(DEB_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DEB_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [DIV_W-1:0]               div_q, div_d;
    logic                           sample_en;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           dir_q, dir_d;    // 1 = down-ramp of a center-aligned period
    logic                           mode_q, mode_d;  // 1 = center-aligned
    logic                           start;
    logic                           ps_q;
    logic [CHANNELS-1:0]            pwm_w;
    logic [CHANNELS-1:0][CNT_W-1:0] duty_w;

    assign sample_en = (div_q == DIV_LAST);
    assign div_d     = sample_en ? '0 : div_q + 1'b1;
    assign start     = (cnt_q == '0) && !dir_q;
    assign mode_d    = start ? bus_if.center : mode_q;

    // Center mode holds PERIOD-1 for one extra cycle at the turnaround and 0 at the
    // end of the down-ramp, giving exactly 2*PERIOD counts per period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        dir_d = dir_q;
        if (!mode_d) begin
            dir_d = 1'b0;
            if (cnt_q == CNT_LAST)
                cnt_d = '0;
        end else if (!dir_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = cnt_q;
                dir_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                cnt_d = '0;
                dir_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            mode_q <= 1'b0;
            ps_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            ps_q   <= start;   // aligned with the registered pwm outputs
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .CNT_W    (CNT_W),
            .PERIOD   (PERIOD),
            .STEP     (STEP),
            .INIT_DUTY(INIT_DUTY)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .sample_en_i(sample_en),
            .inc_i      (bus_if.inc[i]),
            .dec_i      (bus_if.dec[i]),
            .load_i     (bus_if.load_valid && (bus_if.load_ch == 4'(i))),
            .load_duty_i(bus_if.load_duty),
            .start_i    (start),
            .cnt_i      (cnt_q),
            .pwm_o      (pwm_w[i]),
            .duty_o     (duty_w[i])
        );
    end

    assign bus_if.pwm_out      = pwm_w;
    assign bus_if.duty_out     = duty_w;
    assign bus_if.period_start = ps_q;
endmodule
